// File: rtl/arp_pkg.sv
// Shared constants, state encoding and payload helper for the ARP reply path.
package arp_pkg;

  // Fixed ARP header fields for Ethernet / IPv4.
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP   = 16'h0002;

  // 28-byte ARP payload streamed as 56 nibbles.
  localparam int ARP_NIBBLES   = 56;
  localparam int ARP_PAYLOAD_W = ARP_NIBBLES * 4;

  // Controller states. The encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } arp_ctrl_state_t;

  // Whole reply payload, first transmitted nibble in the top four bits.
  // own_mac/own_ip fill SHA/SPA; tha/tpa are the requester's addresses.
  function automatic logic [ARP_PAYLOAD_W-1:0] arp_payload(
    input logic [47:0] own_mac,
    input logic [31:0] own_ip,
    input logic [47:0] tha,
    input logic [31:0] tpa
  );
    return {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN, ARP_OPER_REP,
            own_mac, own_ip, tha, tpa};
  endfunction

endpackage

// File: rtl/arp_reply_ser.sv
// Combinational nibble selector for the ARP reply payload.
// Picks nibble nib_idx (0 = first on the wire) out of the full reply and
// flags the final nibble.
module arp_reply_ser
  import arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0132
) (
  input  logic [5:0]  nib_idx,
  input  logic [47:0] sha,
  input  logic [31:0] spa,
  output logic [3:0]  tx_data,
  output logic        tx_last
);

  logic [ARP_PAYLOAD_W-1:0] payload;
  logic [ARP_PAYLOAD_W-1:0] shifted;

  // Shift the selected nibble to the top of the payload vector and take it.
  always_comb begin
    payload = arp_payload(LOCAL_MAC, LOCAL_IP, sha, spa);
    shifted = payload << {nib_idx, 2'b00};
    tx_data = shifted[ARP_PAYLOAD_W-1 -: 4];
    tx_last = (nib_idx == 6'(ARP_NIBBLES - 1));
  end

endmodule

// File: rtl/arp_reply_ctrl.sv
// ARP reply sequencer.
// Filters decoded ARP requests addressed to LOCAL_IP, holds one active and
// one pending reply, requests the shared TX nibble path and streams the
// 56-nibble reply payload to the framer.
//
// TX handshake: a nibble transfers on every rising clk edge where
// tx_valid && tx_ready. Once tx_valid rises it stays high until the nibble
// flagged tx_last has transferred, and tx_data/tx_last do not change while
// tx_valid && !tx_ready. tx_req covers arbitration and the whole payload;
// tx_gnt is only looked at while arbitrating and is assumed to stay high
// until tx_req drops.
module arp_reply_ctrl
  import arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0132,
  parameter int          CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_done,
  input  logic                  dec_err,
  input  logic [47:0]           dec_sha,
  input  logic [31:0]           dec_spa,
  input  logic [31:0]           dec_tpa,
  output logic                  tx_req,
  input  logic                  tx_gnt,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [3:0]            tx_data,
  output logic                  tx_last,
  output logic [47:0]           tx_dst_mac,
  output logic                  busy,
  output logic [CNT_W-1:0]      reply_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output arp_ctrl_state_t       state_dbg
);

  // Saturating increment: counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  arp_ctrl_state_t state, state_d;

  logic        done_q;
  logic [5:0]  nib_idx;
  logic [47:0] act_sha;
  logic [31:0] act_spa;
  logic        pend_vld;
  logic [47:0] pend_sha;
  logic [31:0] pend_spa;

  // Datapath controls decided by the FSM.
  logic accept;
  logic act_ld_new;
  logic act_ld_pend;
  logic pend_wr;
  logic pend_clr;
  logic drop_inc;
  logic reply_inc;
  logic nib_inc;
  logic nib_clr;

  logic [3:0] ser_data;
  logic       ser_last;

  // A request is taken once, on the rising edge of dec_done, if it is
  // error-free and targets our IP. Replies never reach here, so no OPER test.
  assign accept = dec_done && !done_q && !dec_err && (dec_tpa == LOCAL_IP);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, TX strobes and datapath controls.
  always_comb begin
    state_d     = state;
    tx_req      = 1'b0;
    tx_valid    = 1'b0;
    act_ld_new  = 1'b0;
    act_ld_pend = 1'b0;
    pend_wr     = 1'b0;
    pend_clr    = 1'b0;
    drop_inc    = 1'b0;
    reply_inc   = 1'b0;
    nib_inc     = 1'b0;
    nib_clr     = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          act_ld_new = 1'b1;
          state_d    = ARB;
        end
      end

      ARB: begin
        tx_req = 1'b1;
        // Active reply is frozen; new requests go to the pending slot,
        // the newest one replacing any request already waiting there.
        if (accept) begin
          pend_wr  = 1'b1;
          drop_inc = pend_vld;
        end
        if (tx_gnt) begin
          nib_clr = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        tx_req   = 1'b1;
        tx_valid = 1'b1;
        if (accept) begin
          pend_wr  = 1'b1;
          drop_inc = pend_vld;
        end
        if (tx_ready) begin
          if (nib_idx == 6'(ARP_NIBBLES - 1)) begin
            reply_inc = 1'b1;
            nib_clr   = 1'b1;
            state_d   = RELEASE;
          end else begin
            nib_inc = 1'b1;
          end
        end
      end

      RELEASE: begin
        // One cycle with tx_req low so the arbiter can reassign the path.
        if (pend_vld) begin
          act_ld_pend = 1'b1;
          state_d     = ARB;
          // A simultaneous request refills the slot being emptied: no drop.
          if (accept) begin
            pend_wr = 1'b1;
          end else begin
            pend_clr = 1'b1;
          end
        end else if (accept) begin
          act_ld_new = 1'b1;
          state_d    = ARB;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Edge detector for dec_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= dec_done;
    end
  end

  // Active reply addresses; only reloaded when leaving IDLE or RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_sha <= '0;
      act_spa <= '0;
    end else if (act_ld_new) begin
      act_sha <= dec_sha;
      act_spa <= dec_spa;
    end else if (act_ld_pend) begin
      act_sha <= pend_sha;
      act_spa <= pend_spa;
    end
  end

  // Single-entry pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_sha <= '0;
      pend_spa <= '0;
    end else if (pend_wr) begin
      pend_vld <= 1'b1;
      pend_sha <= dec_sha;
      pend_spa <= dec_spa;
    end else if (pend_clr) begin
      pend_vld <= 1'b0;
    end
  end

  // Payload nibble index, advanced on each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_idx <= '0;
    end else if (nib_clr) begin
      nib_idx <= '0;
    end else if (nib_inc) begin
      nib_idx <= nib_idx + 6'd1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reply_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (reply_inc) begin
        reply_cnt <= sat_inc(reply_cnt);
      end
      if (drop_inc) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  arp_reply_ser #(
    .LOCAL_MAC (LOCAL_MAC),
    .LOCAL_IP  (LOCAL_IP)
  ) u_ser (
    .nib_idx (nib_idx),
    .sha     (act_sha),
    .spa     (act_spa),
    .tx_data (ser_data),
    .tx_last (ser_last)
  );

  // Data lines read zero outside the payload so reset and idle look quiet.
  always_comb begin
    tx_data    = tx_valid ? ser_data : 4'h0;
    tx_last    = tx_valid && ser_last;
    tx_dst_mac = act_sha;
    busy       = (state != IDLE);
    state_dbg  = state;
  end

endmodule
